// File: rtl/m_32_unload_if.sv
// Handshake/bus bundle between the merge-network unloader and its neighbours.
// The master side drives the control strobes, the snapshot vector and out_ready.
// The slave side (the unloader) returns the element stream and its status.
interface m_32_unload_if #(
    parameter int WIDTH = 3,
    parameter int n     = 16,
    parameter int IDXW  = $clog2(2*n)
);
    logic                    start;
    logic                    flush;
    logic [2*n*WIDTH-1:0]    c_in;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [IDXW-1:0]         out_idx;
    logic                    out_last;
    logic                    busy;
    logic                    done;
    logic                    sort_err;

    modport master (
        output start, flush, c_in, out_ready,
        input  out_data, out_valid, out_idx, out_last, busy, done, sort_err
    );

    modport slave (
        input  start, flush, c_in, out_ready,
        output out_data, out_valid, out_idx, out_last, busy, done, sort_err
    );
endinterface

// File: rtl/m_32_unload.sv
// Reader/serializer for the 32-element odd-even merge network output.
// Snapshots the merged vector on start, streams it lowest index first over a
// valid/ready handshake and flags any element smaller than its predecessor.
module m_32_unload #(
    parameter int WIDTH = 3,
    parameter int n     = 16,
    parameter int IDXW  = $clog2(2*n)
) (
    input  logic            clk,
    input  logic            rst,      // asynchronous, active-low
    m_32_unload_if.slave    bus
);
    localparam int              NELEM    = 2*n;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NELEM-1);

    typedef enum logic {S_IDLE, S_STREAM} state_t;

    state_t                  state_q, state_d;
    logic [NELEM*WIDTH-1:0]  shadow_q, shadow_d;
    logic [IDXW-1:0]         idx_q, idx_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    // Shadow register viewed as an array of elements.
    logic [WIDTH-1:0]        elem [NELEM];
    logic [WIDTH-1:0]        cur_elem;
    logic [WIDTH-1:0]        prev_elem;
    logic                    handshake;

    generate
        for (genvar gi = 0; gi < NELEM; gi++) begin : g_elem
            assign elem[gi] = shadow_q[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // The shadow is frozen for the whole frame, so the previously accepted
    // element is always the one just below the current index.
    assign cur_elem  = elem[idx_q];
    assign prev_elem = elem[idx_q - IDXW'(1)];
    assign handshake = (state_q == S_STREAM) && bus.out_ready;

    // State, snapshot, index and status registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            shadow_q <= '0;
            idx_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Next-state logic: flush beats start and handshake; start is only honoured
    // in IDLE or together with the final handshake (back-to-back frames).
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        idx_d    = idx_q;
        done_d   = 1'b0;
        err_d    = err_q;

        if (bus.flush) begin
            state_d = S_IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        shadow_d = bus.c_in;
                        idx_d    = '0;
                        err_d    = 1'b0;
                        state_d  = S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (handshake) begin
                        if ((idx_q != '0) && (cur_elem < prev_elem)) begin
                            err_d = 1'b1;
                        end
                        if (idx_q == LAST_IDX) begin
                            done_d = 1'b1;
                            idx_d  = '0;
                            if (bus.start) begin
                                shadow_d = bus.c_in;
                                err_d    = 1'b0;
                                state_d  = S_STREAM;
                            end else begin
                                state_d  = S_IDLE;
                            end
                        end else begin
                            idx_d = idx_q + IDXW'(1);
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end
            endcase
        end
    end

    assign bus.out_valid = (state_q == S_STREAM);
    assign bus.busy      = (state_q == S_STREAM);
    assign bus.out_data  = (state_q == S_STREAM) ? cur_elem : '0;
    assign bus.out_idx   = idx_q;
    assign bus.out_last  = (state_q == S_STREAM) && (idx_q == LAST_IDX);
    assign bus.done      = done_q;
    assign bus.sort_err  = err_q;
endmodule

// File: tb/tb_m_32_unload.sv
// Self-checking bench for m_32_unload: directed scenarios plus randomized
// frames, compared every cycle against a frame-level behavioural model.
module tb_m_32_unload;
    localparam int WIDTH = 3;
    localparam int N     = 16;
    localparam int NE    = 2*N;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    m_32_unload_if #(.WIDTH(WIDTH), .n(N)) bus ();

    m_32_unload #(.WIDTH(WIDTH), .n(N)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: the captured frame, the position of the next element
    // to be delivered, the last accepted value and the per-frame error flag.
    logic [WIDTH-1:0] m_frame [NE];
    logic             m_active = 1'b0;
    int               m_pos    = 0;
    logic [WIDTH-1:0] m_prev   = '0;
    logic             m_err    = 1'b0;
    logic             m_done   = 1'b0;
    int               m_frames = 0;

    logic [WIDTH-1:0] gen [NE];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [NE*WIDTH-1:0] pack_gen();
        logic [NE*WIDTH-1:0] v;
        v = '0;
        for (int k = 0; k < NE; k++) v[k*WIDTH +: WIDTH] = gen[k];
        return v;
    endfunction

    task automatic sort_gen();
        logic [WIDTH-1:0] t;
        for (int i = 0; i < NE; i++)
            for (int j = 0; j < NE-1-i; j++)
                if (gen[j] > gen[j+1]) begin
                    t = gen[j]; gen[j] = gen[j+1]; gen[j+1] = t;
                end
    endtask

    task automatic model_capture(input logic [NE*WIDTH-1:0] cv);
        for (int k = 0; k < NE; k++) m_frame[k] = cv[k*WIDTH +: WIDTH];
        m_pos    = 0;
        m_err    = 1'b0;
        m_active = 1'b1;
    endtask

    task automatic model_update(input logic st, input logic fl, input logic rdy,
                                input logic [NE*WIDTH-1:0] cv);
        m_done = 1'b0;
        if (fl) begin
            m_active = 1'b0;
            m_pos    = 0;
        end else if (!m_active) begin
            if (st) model_capture(cv);
        end else if (rdy) begin
            if (m_pos > 0 && m_frame[m_pos] < m_prev) m_err = 1'b1;
            m_prev = m_frame[m_pos];
            if (m_pos == NE-1) begin
                m_done = 1'b1;
                m_frames++;
                $display("frame %0d complete sort_err=%0d", m_frames, m_err);
                if (st) model_capture(cv);
                else begin
                    m_active = 1'b0;
                    m_pos    = 0;
                end
            end else begin
                m_pos++;
            end
        end
    endtask

    task automatic check_outputs();
        logic [WIDTH-1:0] exp_data;
        exp_data = m_active ? m_frame[m_pos] : '0;
        check("out_valid", 32'(bus.out_valid), 32'(m_active));
        check("busy",      32'(bus.busy),      32'(m_active));
        check("out_idx",   32'(bus.out_idx),   32'(m_pos));
        check("out_data",  32'(bus.out_data),  32'(exp_data));
        check("out_last",  32'(bus.out_last),  32'(m_active && m_pos == NE-1));
        check("done",      32'(bus.done),      32'(m_done));
        check("sort_err",  32'(bus.sort_err),  32'(m_err));
    endtask

    // One clock: drive inputs, model the edge, check outputs on the falling edge.
    task automatic step(input logic st, input logic fl, input logic rdy,
                        input logic [NE*WIDTH-1:0] cv);
        bus.start     = st;
        bus.flush     = fl;
        bus.out_ready = rdy;
        bus.c_in      = cv;
        @(posedge clk);
        model_update(st, fl, rdy, cv);
        @(negedge clk);
        check_outputs();
    endtask

    function automatic logic [NE*WIDTH-1:0] rand_vec();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NE*WIDTH-1:0] ramp, bad, sevens, cv;
        int cyc;

        bus.start = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b0; bus.c_in = '0;
        for (int k = 0; k < NE; k++) gen[k] = WIDTH'(k >> 2);
        ramp = pack_gen();
        gen[10] = '0;
        bad = pack_gen();
        for (int k = 0; k < NE; k++) gen[k] = 3'd7;
        sevens = pack_gen();

        // Reset state.
        repeat (2) @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b1, rand_vec());
        $display("scenario reset checked");

        // 1: ramp, ready held high.
        step(1'b1, 1'b0, 1'b1, ramp);
        for (int c = 0; c < NE + 2; c++) step(1'b0, 1'b0, 1'b1, rand_vec());
        $display("scenario ramp checked");

        // 2: ramp with ready toggling.
        step(1'b1, 1'b0, 1'b0, ramp);
        for (int c = 0; c < 2*NE + 2; c++) step(1'b0, 1'b0, 1'(c % 2 == 0), rand_vec());
        $display("scenario toggled ready checked");

        // 3: order violation at element 10, then cleared by a new start.
        step(1'b1, 1'b0, 1'b1, bad);
        for (int c = 0; c < NE + 2; c++) step(1'b0, 1'b0, 1'b1, rand_vec());
        step(1'b1, 1'b0, 1'b1, ramp);
        step(1'b0, 1'b1, 1'b0, ramp);
        $display("scenario order error checked");

        // 4: start ignored mid-frame, honoured on the final handshake.
        step(1'b1, 1'b0, 1'b1, ramp);
        cyc = 0;
        while (m_active && cyc < 100) begin
            cyc++;
            step(1'(m_pos == 5 || m_pos == NE-1), 1'b0, 1'b1,
                 (m_pos == NE-1) ? sevens : rand_vec());
            if (m_pos == 0 && m_frame[0] == 3'd7) break;
        end
        check("b2b_restart", 32'(bus.out_valid), 32'd1);
        for (int c = 0; c < NE + 2; c++) step(1'b0, 1'b0, 1'b1, rand_vec());
        $display("scenario back-to-back checked");

        // 5: flush at idx 12, then a full frame.
        step(1'b1, 1'b0, 1'b1, ramp);
        while (m_active && m_pos < 12) step(1'b0, 1'b0, 1'b1, rand_vec());
        step(1'b1, 1'b1, 1'b1, sevens);
        step(1'b0, 1'b1, 1'b0, sevens);
        step(1'b1, 1'b0, 1'b1, ramp);
        for (int c = 0; c < NE + 2; c++) step(1'b0, 1'b0, 1'b1, rand_vec());
        $display("scenario flush checked");

        // 6: asynchronous reset mid-cycle at idx 20 after an error.
        step(1'b1, 1'b0, 1'b1, bad);
        while (m_active && m_pos < 20) step(1'b0, 1'b0, 1'b1, rand_vec());
        #2 rst_n = 1'b0;
        #1;
        m_active = 1'b0; m_pos = 0; m_err = 1'b0; m_done = 1'b0;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b1, rand_vec());
        step(1'b0, 1'b0, 1'b1, rand_vec());
        $display("scenario async reset checked");

        // Randomized frames with backpressure, stray starts, flushes and c_in churn.
        for (int f = 0; f < 20; f++) begin
            for (int k = 0; k < NE; k++) gen[k] = WIDTH'($urandom_range(0, 7));
            if (f % 2 == 0) sort_gen();
            cv = pack_gen();
            step(1'b1, 1'b0, 1'($urandom_range(0, 1)), cv);
            cyc = 0;
            while (m_active && cyc < 300) begin
                cyc++;
                step(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 79) == 0),
                     1'($urandom_range(0, 3) != 0), rand_vec());
            end
            step(1'b0, 1'($urandom_range(0, 1)), 1'b1, rand_vec());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
